control_unit: RTL and testbench

- Fetch/decode/execute sequencer that sits directly upstream of ALU and the register file.
- Fetches 16-bit instructions from a synchronous-read program memory.
- Drives ALU OP and immediate operand (ALU IN0), selects the ALU IN1 source register, and pulses clock enables for ACC and general registers R0..R3.
- Latches ALU ZF for conditional jumps.

---
 rtl/control_unit.sv | 131 +++++++++++++
 tb/tb_control_unit.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/control_unit.sv
// Fetch/decode/execute sequencer for a small accumulator datapath.
// Each instruction takes exactly three cycles (FETCH, DECODE, EXECUTE).
// It drives the ALU opcode and immediate, selects the ALU IN1 register,
// and pulses one-cycle clock enables for ACC and R0..R3.
// A SYS HALT instruction parks the unit in HALT until nRST is asserted.
module control_unit #(
  parameter int DATA_WIDTH  = 8,
  parameter int OP_WIDTH    = 4,
  parameter int INSTR_WIDTH = 2 + 2 + OP_WIDTH + DATA_WIDTH
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic [INSTR_WIDTH-1:0] INSTR,
  input  logic                   ZF,
  output logic [DATA_WIDTH-1:0]  PC,
  output logic [OP_WIDTH-1:0]    OP,
  output logic [DATA_WIDTH-1:0]  IMM,
  output logic [1:0]             R_SEL,
  output logic                   ACC_CE,
  output logic [3:0]             R_CE,
  output logic                   Z_FLAG,
  output logic                   HALTED
);

  typedef enum logic [1:0] {
    S_FETCH   = 2'd0,
    S_DECODE  = 2'd1,
    S_EXECUTE = 2'd2,
    S_HALT    = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    C_ALU = 2'b00,
    C_MOV = 2'b01,
    C_JMP = 2'b10,
    C_SYS = 2'b11
  } class_e;

  state_e                   state_q, state_d;
  logic [DATA_WIDTH-1:0]    pc_q, pc_d;
  logic [INSTR_WIDTH-1:0]   ir_q, ir_d;
  logic                     z_flag_q, z_flag_d;

  class_e                   ir_class;
  logic [1:0]               ir_reg;
  logic [OP_WIDTH-1:0]      ir_op;
  logic [DATA_WIDTH-1:0]    ir_imm;
  logic                     jump_taken;
  logic                     acc_ce;
  logic [3:0]               r_ce;

  // Instruction field extraction: [15:14] class, [13:12] reg, [11:8] op, [7:0] imm.
  assign ir_class = class_e'(ir_q[INSTR_WIDTH-1 -: 2]);
  assign ir_reg   = ir_q[INSTR_WIDTH-3 -: 2];
  assign ir_op    = ir_q[DATA_WIDTH +: OP_WIDTH];
  assign ir_imm   = ir_q[DATA_WIDTH-1:0];

  // Jump condition evaluated on the flag latched by an earlier ALU instruction.
  always_comb begin
    case (ir_op[1:0])
      2'b00:   jump_taken = 1'b1;
      2'b01:   jump_taken = z_flag_q;
      2'b10:   jump_taken = ~z_flag_q;
      default: jump_taken = 1'b0;
    endcase
  end

  // Next-state, next-PC, IR capture and enable decode.
  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    z_flag_d = z_flag_q;
    acc_ce   = 1'b0;
    r_ce     = 4'b0000;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        ir_d    = INSTR;
        state_d = S_EXECUTE;
      end
      S_EXECUTE: begin
        state_d = S_FETCH;
        pc_d    = pc_q + DATA_WIDTH'(1);
        case (ir_class)
          C_ALU: begin
            acc_ce   = 1'b1;
            z_flag_d = ZF;
          end
          C_MOV: r_ce = 4'b0001 << ir_reg;
          C_JMP: if (jump_taken) pc_d = ir_imm;
          C_SYS: if (ir_op[0]) begin
            state_d = S_HALT;
            pc_d    = pc_q;
          end
          default: ;
        endcase
      end
      default: state_d = S_HALT;
    endcase
  end

  // State, PC, IR and zero-flag registers.
  always_ff @(posedge CLK or negedge nRST) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!nRST) begin
      state_q  <= S_FETCH;
      pc_q     <= '0;
      ir_q     <= '0;
      z_flag_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      z_flag_q <= z_flag_d;
    end
  end

  // Output mapping; the enables decode only the asynchronously reset state
  // register, so they fall the moment nRST is asserted.
  assign PC     = pc_q;
  assign OP     = ir_op;
  assign IMM    = ir_imm;
  assign R_SEL  = ir_reg;
  assign ACC_CE = acc_ce;
  assign R_CE   = r_ce;
  assign Z_FLAG = z_flag_q;
  assign HALTED = (state_q == S_HALT);

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: a behavioural synchronous-read ROM and
// an ALU zero-flag stub drive the sequencer through a hand-written program.
module tb_control_unit;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic [15:0] INSTR = 16'h0000;
  logic        ZF = 1'b0;
  logic [7:0]  PC;
  logic [3:0]  OP;
  logic [7:0]  IMM;
  logic [1:0]  R_SEL;
  logic        ACC_CE;
  logic [3:0]  R_CE;
  logic        Z_FLAG;
  logic        HALTED;

  logic [15:0] rom [256];
  int          checks = 0;
  int          failures = 0;

  typedef struct {
    logic [7:0]  pc;
    logic [15:0] ins;
    logic        zf;
    logic        acc;
    logic [3:0]  rce;
    logic [7:0]  npc;
    logic        zfl;
  } vec_t;

  vec_t prog [11];

  control_unit dut (
    .CLK(CLK), .nRST(nRST), .INSTR(INSTR), .ZF(ZF),
    .PC(PC), .OP(OP), .IMM(IMM), .R_SEL(R_SEL),
    .ACC_CE(ACC_CE), .R_CE(R_CE), .Z_FLAG(Z_FLAG), .HALTED(HALTED)
  );

  always #5 CLK = ~CLK;

  // Synchronous-read program memory.
  always @(posedge CLK) INSTR <= rom[PC];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_pc"}, 32'(PC), 32'h00);
    check({tag, "_op_imm_rsel"}, {18'd0, OP, IMM, R_SEL}, 32'd0);
    check({tag, "_ce"}, {27'd0, ACC_CE, R_CE}, 32'd0);
    check({tag, "_zflag_halted"}, {30'd0, Z_FLAG, HALTED}, 32'd0);
  endtask

  // Runs one instruction from its FETCH cycle to the next FETCH.
  task automatic run_instr(input vec_t v);
    logic [15:0] w;
    w = v.ins;
    check("fetch_pc", 32'(PC), 32'(v.pc));
    check("fetch_ce", {27'd0, ACC_CE, R_CE}, 32'd0);
    ZF = v.zf;
    tick();
    check("decode_ce", {27'd0, ACC_CE, R_CE}, 32'd0);
    tick();
    check("exec_acc_ce", 32'(ACC_CE), 32'(v.acc));
    check("exec_r_ce", 32'(R_CE), 32'(v.rce));
    check("exec_op", 32'(OP), 32'(w[11:8]));
    check("exec_imm", 32'(IMM), 32'(w[7:0]));
    check("exec_r_sel", 32'(R_SEL), 32'(w[13:12]));
    check("exec_halted", 32'(HALTED), 32'd0);
    tick();
    check("next_pc", 32'(PC), 32'(v.npc));
    check("z_flag", 32'(Z_FLAG), 32'(v.zfl));
    check("next_ce", {27'd0, ACC_CE, R_CE}, 32'd0);
    ZF = 1'b0;
  endtask

  initial begin
    //          pc     instr     zf    acc   r_ce   next   z_flag
    prog[0]  = '{8'h00, 16'h0A55, 1'b1, 1'b1, 4'h0, 8'h01, 1'b1}; // ALU, ZF=1
    prog[1]  = '{8'h01, 16'h5000, 1'b0, 1'b0, 4'h2, 8'h02, 1'b1}; // MOV R1
    prog[2]  = '{8'h02, 16'h9110, 1'b0, 1'b0, 4'h0, 8'h10, 1'b1}; // JZ taken
    prog[3]  = '{8'h10, 16'h3000, 1'b0, 1'b1, 4'h0, 8'h11, 1'b0}; // ALU R3, ZF=0
    prog[4]  = '{8'h11, 16'h9120, 1'b1, 1'b0, 4'h0, 8'h12, 1'b0}; // JZ not taken, live ZF ignored
    prog[5]  = '{8'h12, 16'h9230, 1'b0, 1'b0, 4'h0, 8'h30, 1'b0}; // JNZ taken
    prog[6]  = '{8'h30, 16'h7000, 1'b1, 1'b0, 4'h8, 8'h31, 1'b0}; // MOV R3, ZF ignored
    prog[7]  = '{8'h31, 16'h0000, 1'b1, 1'b1, 4'h0, 8'h32, 1'b1}; // ALU, ZF=1
    prog[8]  = '{8'h32, 16'h9240, 1'b0, 1'b0, 4'h0, 8'h33, 1'b1}; // JNZ not taken
    prog[9]  = '{8'h33, 16'h83FF, 1'b0, 1'b0, 4'h0, 8'h34, 1'b1}; // JMP never
    prog[10] = '{8'h34, 16'h80FF, 1'b0, 1'b0, 4'h0, 8'hFF, 1'b1}; // JMP always

    for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
    for (int i = 0; i < 11; i++) rom[prog[i].pc] = prog[i].ins;
    rom[8'hFF] = 16'hC000; // NOP at the top of memory
    rom[8'h00] = 16'h0A55;

    // Reset state.
    #1;
    check_reset_outputs("reset");
    tick();
    tick();
    nRST = 1'b1;

    // Main program, then PC wrap from 0xFF.
    for (int i = 0; i < 11; i++) run_instr(prog[i]);
    run_instr('{8'hFF, 16'hC000, 1'b0, 1'b0, 4'h0, 8'h00, 1'b1});

    // Reset asserted in the middle of an ALU EXECUTE.
    tick();
    tick();
    check("mid_exec_acc_ce", 32'(ACC_CE), 32'd1);
    #2 nRST = 1'b0;
    #1;
    check_reset_outputs("mid_exec_reset");
    tick();
    check_reset_outputs("held_reset");

    // HALT at address 3 after three NOPs; restart from PC=0.
    rom[0] = 16'hC000;
    rom[1] = 16'hC000;
    rom[2] = 16'hC000;
    rom[3] = 16'hC100;
    nRST = 1'b1;
    for (int i = 0; i < 3; i++)
      run_instr('{8'(i), 16'hC000, 1'b0, 1'b0, 4'h0, 8'(i + 1), 1'b0});
    run_instr('{8'h03, 16'hC100, 1'b0, 1'b0, 4'h0, 8'h03, 1'b0});
    for (int i = 0; i < 20; i++) begin
      check("halt_halted", 32'(HALTED), 32'd1);
      check("halt_pc", 32'(PC), 32'h03);
      check("halt_ce", {27'd0, ACC_CE, R_CE}, 32'd0);
      tick();
    end

    // Reset leaves HALT.
    nRST = 1'b0;
    #1;
    check_reset_outputs("halt_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
